// File: rtl/hazard_scoreboard_if.sv
// Decode/write-back bus seen by the hazard scoreboard: ID operands, WB retire
// and the stall/issue/flush decisions returned to the pipeline.
interface hazard_scoreboard_if;
    logic        id_valid;
    logic [3:0]  src_rn;
    logic [3:0]  src_rm;
    logic        two_src;
    logic        id_wb_en;
    logic [3:0]  id_dest;
    logic        id_s;
    logic        id_cond_al;
    logic        branch_taken;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic        wb_s;
    logic        stall;
    logic        issue;
    logic        flush;
    logic [15:0] pending;
    logic [15:0] stall_cycles;
    logic        underflow_err;

    modport slave (
        input  id_valid, src_rn, src_rm, two_src, id_wb_en, id_dest, id_s,
               id_cond_al, branch_taken, wb_en, wb_dest, wb_s,
        output stall, issue, flush, pending, stall_cycles, underflow_err
    );

    modport master (
        output id_valid, src_rn, src_rm, two_src, id_wb_en, id_dest, id_s,
               id_cond_al, branch_taken, wb_en, wb_dest, wb_s,
        input  stall, issue, flush, pending, stall_cycles, underflow_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: per-register and flag in-flight counters, stall/issue/flush.
// Optional macro HAZARD_WB_BYPASS_EN: a count of 1 retiring this cycle is not a hazard.
module hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt_q [16];
    logic [CNT_W-1:0] cnt_d [16];
    logic [CNT_W-1:0] flag_cnt_q;
    logic [CNT_W-1:0] flag_cnt_d;
    logic [15:0]      stall_cycles_q;
    logic [15:0]      stall_cycles_d;
    logic             underflow_err_q;
    logic             underflow_err_d;

    logic [15:0] dest_oh_s;
    logic [15:0] wb_oh_s;
    logic [15:0] pending_s;
    logic [15:0] busy_s;
    logic        flag_pending_s;
    logic        flag_busy_s;
    logic        hazard_rn_s;
    logic        hazard_rm_s;
    logic        hazard_flags_s;
    logic        full_s;
    logic        stall_s;
    logic        issue_s;

    assign dest_oh_s = 16'h0001 << sb.id_dest;
    assign wb_oh_s   = 16'h0001 << sb.wb_dest;

    // Busy view: pending counts, optionally excluding a last write retiring now
    always_comb begin
        pending_s = 16'h0000;
        busy_s    = 16'h0000;
        for (int r = 0; r < 16; r++) begin
            pending_s[r] = (cnt_q[r] != CNT_ZERO);
`ifdef HAZARD_WB_BYPASS_EN
            busy_s[r] = pending_s[r] & ~((cnt_q[r] == CNT_ONE) & sb.wb_en & wb_oh_s[r]);
`else
            busy_s[r] = pending_s[r];
`endif
        end
        flag_pending_s = (flag_cnt_q != CNT_ZERO);
`ifdef HAZARD_WB_BYPASS_EN
        flag_busy_s = flag_pending_s & ~((flag_cnt_q == CNT_ONE) & sb.wb_s);
`else
        flag_busy_s = flag_pending_s;
`endif
    end

    // Hazard detection; a taken branch overrides any stall
    always_comb begin
        hazard_rn_s    = busy_s[sb.src_rn];
        hazard_rm_s    = sb.two_src & busy_s[sb.src_rm];
        hazard_flags_s = ~sb.id_cond_al & flag_busy_s;
        full_s         = (sb.id_wb_en & (cnt_q[sb.id_dest] == CNT_MAX))
                       | (sb.id_s & (flag_cnt_q == CNT_MAX));
        stall_s        = sb.id_valid & ~sb.branch_taken
                       & (hazard_rn_s | hazard_rm_s | hazard_flags_s | full_s);
        issue_s        = sb.id_valid & ~stall_s & ~sb.branch_taken;
    end

    // Counter next-state: issue adds, retire subtracts, retire on zero is flagged
    always_comb begin
        underflow_err_d = underflow_err_q;
        flag_cnt_d      = flag_cnt_q;
        stall_cycles_d  = stall_cycles_q;
        for (int r = 0; r < 16; r++) begin
            cnt_d[r] = cnt_q[r];
            case ({issue_s & sb.id_wb_en & dest_oh_s[r], sb.wb_en & wb_oh_s[r]})
                2'b10: cnt_d[r] = cnt_q[r] + CNT_ONE;
                2'b01: begin
                    if (cnt_q[r] == CNT_ZERO) begin
                        cnt_d[r]        = CNT_ZERO;
                        underflow_err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] - CNT_ONE;
                    end
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
        case ({issue_s & sb.id_s, sb.wb_s})
            2'b10: flag_cnt_d = flag_cnt_q + CNT_ONE;
            2'b01: begin
                if (flag_cnt_q == CNT_ZERO) begin
                    flag_cnt_d      = CNT_ZERO;
                    underflow_err_d = 1'b1;
                end else begin
                    flag_cnt_d = flag_cnt_q - CNT_ONE;
                end
            end
            default: flag_cnt_d = flag_cnt_q;
        endcase
        if (stall_s && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'h0001;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            flag_cnt_q      <= CNT_ZERO;
            stall_cycles_q  <= 16'h0000;
            underflow_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            flag_cnt_q      <= flag_cnt_d;
            stall_cycles_q  <= stall_cycles_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign sb.stall         = stall_s;
    assign sb.issue         = issue_s;
    assign sb.flush         = sb.branch_taken;
    assign sb.pending       = pending_s;
    assign sb.stall_cycles  = stall_cycles_q;
    assign sb.underflow_err = underflow_err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plus randomized bench for hazard_scoreboard against a counting model.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if sb_if();

    hazard_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

`ifdef HAZARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int MAXF = 3;

    int n_vec  = 0;
    int n_miss = 0;
    int mcnt [16];
    int mfcnt;
    int mstall;
    bit munder;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reg_busy(input int r);
        return (mcnt[r] > 0) &&
               !(BYPASS && mcnt[r] == 1 && sb_if.wb_en && int'(sb_if.wb_dest) == r);
    endfunction

    function automatic bit flag_busy();
        return (mfcnt > 0) && !(BYPASS && mfcnt == 1 && sb_if.wb_s);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 16; r++) mcnt[r] = 0;
        mfcnt  = 0;
        mstall = 0;
        munder = 1'b0;
    endtask

    task automatic idle();
        sb_if.id_valid     = 1'b0;
        sb_if.src_rn       = 4'd0;
        sb_if.src_rm       = 4'd0;
        sb_if.two_src      = 1'b0;
        sb_if.id_wb_en     = 1'b0;
        sb_if.id_dest      = 4'd0;
        sb_if.id_s         = 1'b0;
        sb_if.id_cond_al   = 1'b1;
        sb_if.branch_taken = 1'b0;
        sb_if.wb_en        = 1'b0;
        sb_if.wb_dest      = 4'd0;
        sb_if.wb_s         = 1'b0;
    endtask

    // Check every output against the model for the current inputs, then clock once
    task automatic cycle();
        bit es;
        bit ei;
        logic [15:0] ep;
        #1;
        es = sb_if.id_valid && !sb_if.branch_taken &&
             (reg_busy(int'(sb_if.src_rn)) ||
              (sb_if.two_src && reg_busy(int'(sb_if.src_rm))) ||
              (!sb_if.id_cond_al && flag_busy()) ||
              (sb_if.id_wb_en && mcnt[sb_if.id_dest] == MAXF) ||
              (sb_if.id_s && mfcnt == MAXF));
        ei = sb_if.id_valid && !es && !sb_if.branch_taken;
        ep = 16'h0000;
        for (int r = 0; r < 16; r++) ep[r] = (mcnt[r] > 0);
        check("stall", 32'(sb_if.stall), 32'(es));
        check("issue", 32'(sb_if.issue), 32'(ei));
        check("flush", 32'(sb_if.flush), 32'(sb_if.branch_taken));
        check("pending", 32'(sb_if.pending), 32'(ep));
        check("stall_cycles", 32'(sb_if.stall_cycles), 32'(mstall));
        check("underflow_err", 32'(sb_if.underflow_err), 32'(munder));
        if (ei && sb_if.id_wb_en) mcnt[sb_if.id_dest]++;
        if (ei && sb_if.id_s) mfcnt++;
        if (sb_if.wb_en) begin
            if (mcnt[sb_if.wb_dest] == 0) munder = 1'b1;
            else mcnt[sb_if.wb_dest]--;
        end
        if (sb_if.wb_s) begin
            if (mfcnt == 0) munder = 1'b1;
            else mfcnt--;
        end
        if (es && mstall < 65535) mstall++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        int r;
        rst = 1'b1;
        idle();
        model_clear();
        do_reset();
        cycle();

        // Read-after-write on R3, retired at the third stall cycle
        idle(); sb_if.id_valid = 1'b1; sb_if.id_wb_en = 1'b1; sb_if.id_dest = 4'd3; cycle();
        idle(); sb_if.id_valid = 1'b1; sb_if.src_rn = 4'd3;
        #1 check("s1_stall_c1", 32'(sb_if.stall), 32'd1);
        cycle(); cycle();
        sb_if.wb_en = 1'b1; sb_if.wb_dest = 4'd3; cycle();
        sb_if.wb_en = 1'b0; cycle();
        check("s1_stall_cycles", 32'(sb_if.stall_cycles), BYPASS ? 32'd2 : 32'd3);

        // Second source only matters when two_src is set
        idle(); sb_if.id_valid = 1'b1; sb_if.id_wb_en = 1'b1; sb_if.id_dest = 4'd5; cycle();
        idle(); sb_if.id_valid = 1'b1; sb_if.src_rm = 4'd5;
        #1 check("s2_rm_unused_stall", 32'(sb_if.stall), 32'd0);
        check("s2_rm_unused_issue", 32'(sb_if.issue), 32'd1);
        cycle();
        sb_if.two_src = 1'b1;
        #1 check("s2_rm_used_stall", 32'(sb_if.stall), 32'd1);
        cycle();
        idle(); sb_if.wb_en = 1'b1; sb_if.wb_dest = 4'd5; cycle();

        // Fill R7 to the in-flight limit, then a fourth write waits for a retire
        for (int i = 0; i < 3; i++) begin
            idle(); sb_if.id_valid = 1'b1; sb_if.id_wb_en = 1'b1; sb_if.id_dest = 4'd7; cycle();
        end
        #1 check("s3_full_stall", 32'(sb_if.stall), 32'd1);
        cycle();
        sb_if.wb_en = 1'b1; sb_if.wb_dest = 4'd7; cycle();
        sb_if.wb_en = 1'b0;
        #1 check("s3_fourth_issue", 32'(sb_if.issue), 32'd1);
        cycle();
        idle(); sb_if.wb_en = 1'b1; sb_if.wb_dest = 4'd7;
        cycle(); cycle();
        #1 check("s3_r7_still_pending", 32'(sb_if.pending[7]), 32'd1);
        cycle();
        idle();
        #1 check("s3_drained", 32'(sb_if.pending), 32'd0);

        // Flag dependency: conditional waits, AL does not
        idle(); sb_if.id_valid = 1'b1; sb_if.id_s = 1'b1; cycle();
        idle(); sb_if.id_valid = 1'b1; sb_if.id_cond_al = 1'b0;
        #1 check("s4_cond_stall", 32'(sb_if.stall), 32'd1);
        cycle(); cycle();
        sb_if.wb_s = 1'b1; cycle();
        sb_if.wb_s = 1'b0; cycle();
        idle(); sb_if.id_valid = 1'b1; sb_if.id_s = 1'b1; cycle();
        idle(); sb_if.id_valid = 1'b1;
        #1 check("s4_al_no_stall", 32'(sb_if.stall), 32'd0);
        cycle();
        idle(); sb_if.wb_s = 1'b1; cycle();

        // Taken branch beats a pending hazard
        idle(); sb_if.id_valid = 1'b1; sb_if.id_wb_en = 1'b1; sb_if.id_dest = 4'd2; cycle();
        idle(); sb_if.id_valid = 1'b1; sb_if.src_rn = 4'd2; sb_if.branch_taken = 1'b1;
        sb_if.id_wb_en = 1'b1; sb_if.id_dest = 4'd9;
        #1 check("s5_no_stall", 32'(sb_if.stall), 32'd0);
        check("s5_no_issue", 32'(sb_if.issue), 32'd0);
        check("s5_flush", 32'(sb_if.flush), 32'd1);
        cycle();
        idle();
        #1 check("s5_counters_held", 32'(sb_if.pending), 32'h0004);
        sb_if.wb_en = 1'b1; sb_if.wb_dest = 4'd2; cycle();

        // Reset drops tracking; a stale retire then underflows
        for (int i = 0; i < 2; i++) begin
            idle(); sb_if.id_valid = 1'b1; sb_if.id_wb_en = 1'b1; sb_if.id_dest = 4'd4; cycle();
        end
        do_reset();
        #1 check("s6_pending_cleared", 32'(sb_if.pending), 32'd0);
        check("s6_stall_cycles_cleared", 32'(sb_if.stall_cycles), 32'd0);
        sb_if.wb_en = 1'b1; sb_if.wb_dest = 4'd4; cycle();
        idle();
        #1 check("s6_underflow", 32'(sb_if.underflow_err), 32'd1);
        check("s6_no_wrap", 32'(sb_if.pending), 32'd0);

        // Randomized traffic with retires drawn from outstanding writes
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            sb_if.id_valid     = ($urandom_range(3) != 0);
            sb_if.src_rn       = 4'($urandom_range(7));
            sb_if.src_rm       = 4'($urandom_range(7));
            sb_if.two_src      = 1'($urandom_range(1));
            sb_if.id_wb_en     = 1'($urandom_range(1));
            sb_if.id_dest      = 4'($urandom_range(7));
            sb_if.id_s         = ($urandom_range(3) == 0);
            sb_if.id_cond_al   = ($urandom_range(2) != 0);
            sb_if.branch_taken = ($urandom_range(7) == 0);
            r = int'($urandom_range(7));
            if (mcnt[r] > 0 && $urandom_range(2) != 0) begin
                sb_if.wb_en   = 1'b1;
                sb_if.wb_dest = 4'(r);
            end else begin
                sb_if.wb_en   = 1'b0;
                sb_if.wb_dest = 4'($urandom_range(15));
            end
            sb_if.wb_s = (mfcnt > 0) && ($urandom_range(1) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
